// File: rtl/patp_sequencer.sv
// PATP timing/phase sequencer: one-hot T-states, fetch flag, decoded instruction lines,
// run/halt and single-step control, overrun watchdog and retired-instruction counter.
module patp_sequencer #(
  parameter int MAX_T    = 5,
  parameter int ICOUNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                step_mode,
  input  logic                step,
  input  logic [2:0]          opcode,
  input  logic                start_fetch,
  input  logic                start_execute,
  output logic                t1,
  output logic                t2,
  output logic                t3,
  output logic                t4,
  output logic                t5,
  output logic                fetch,
  output logic                clear,
  output logic                inc1,
  output logic                add,
  output logic                dec1,
  output logic                jmp,
  output logic                buz,
  output logic                load,
  output logic                store,
  output logic                halted,
  output logic                paused,
  output logic                overrun,
  output logic [ICOUNT_W-1:0] icount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXECUTE,
    S_STEP_WAIT,
    S_ERROR
  } state_t;

  localparam logic [2:0] T_LAST = 3'(MAX_T);

  state_t              state_reg, state_next;
  logic [2:0]          t_reg, t_next;       // T-state index 1..MAX_T, 0 outside a phase
  logic [2:0]          op_reg, op_next;
  logic [ICOUNT_W-1:0] icount_reg, icount_next;

  logic [4:0] t_oh_reg, t_oh_next;
  logic [7:0] dec_reg, dec_next;
  logic       fetch_reg, halted_reg, paused_reg, overrun_reg;

  always_comb begin
    state_next  = state_reg;
    t_next      = t_reg;
    op_next     = op_reg;
    icount_next = icount_reg;
    case (state_reg)
      S_IDLE: begin
        if (run) begin
          state_next = S_FETCH;
          t_next     = 3'd1;
        end
      end
      S_FETCH: begin
        if (start_fetch && start_execute) begin
          state_next = S_ERROR;
          t_next     = 3'd0;
        end else if (start_execute) begin
          state_next = S_EXECUTE;
          t_next     = 3'd1;
          op_next    = opcode;
        end else if (t_reg == T_LAST) begin
          state_next = S_ERROR;
          t_next     = 3'd0;
        end else begin
          t_next = t_reg + 3'd1;
        end
      end
      S_EXECUTE: begin
        if (start_fetch && start_execute) begin
          state_next = S_ERROR;
          t_next     = 3'd0;
        end else if (start_fetch) begin
          icount_next = icount_reg + ICOUNT_W'(1);
          if (!run) begin
            state_next = S_IDLE;
            t_next     = 3'd0;
          end else if (step_mode) begin
            state_next = S_STEP_WAIT;
            t_next     = 3'd0;
          end else begin
            state_next = S_FETCH;
            t_next     = 3'd1;
          end
        end else if (t_reg == T_LAST) begin
          state_next = S_ERROR;
          t_next     = 3'd0;
        end else begin
          t_next = t_reg + 3'd1;
        end
      end
      S_STEP_WAIT: begin
        if (!run) begin
          state_next = S_IDLE;
        end else if (step) begin
          state_next = S_FETCH;
          t_next     = 3'd1;
        end
      end
      S_ERROR: begin
        state_next = S_ERROR;
      end
      default: begin
        state_next = S_ERROR;
        t_next     = 3'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_t_oh
      assign t_oh_next[gi] = (t_next == 3'(gi + 1));
    end
    for (gi = 0; gi < 8; gi++) begin : g_dec
      assign dec_next[gi] = (state_next == S_EXECUTE) && (op_next == 3'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      t_reg       <= 3'd0;
      op_reg      <= 3'd0;
      icount_reg  <= '0;
      t_oh_reg    <= 5'd0;
      dec_reg     <= 8'd0;
      fetch_reg   <= 1'b0;
      halted_reg  <= 1'b1;
      paused_reg  <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      t_reg       <= t_next;
      op_reg      <= op_next;
      icount_reg  <= icount_next;
      t_oh_reg    <= t_oh_next;
      dec_reg     <= dec_next;
      fetch_reg   <= (state_next == S_FETCH);
      halted_reg  <= (state_next == S_IDLE);
      paused_reg  <= (state_next == S_STEP_WAIT);
      overrun_reg <= (state_next == S_ERROR);
    end
  end

  assign {t5, t4, t3, t2, t1} = t_oh_reg;
  assign {store, load, buz, jmp, dec1, add, inc1, clear} = dec_reg;
  assign fetch   = fetch_reg;
  assign halted  = halted_reg;
  assign paused  = paused_reg;
  assign overrun = overrun_reg;
  assign icount  = icount_reg;

endmodule

// File: tb/tb_patp_sequencer.sv
// Scoreboard bench for patp_sequencer: a phase-level reference model queues the expected
// outputs for every clock; a monitor pops and compares them after each rising edge.
module tb_patp_sequencer;

  localparam int MAX_T = 5;
  localparam int IW    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0, step_mode = 1'b0, step = 1'b0;
  logic start_fetch = 1'b0, start_execute = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic t1, t2, t3, t4, t5, fetch;
  logic clear, inc1, add, dec1, jmp, buz, load, store;
  logic halted, paused, overrun;
  logic [IW-1:0] icount;

  always #5 clk = ~clk;

  patp_sequencer #(.MAX_T(MAX_T), .ICOUNT_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step_mode(step_mode), .step(step),
    .opcode(opcode), .start_fetch(start_fetch), .start_execute(start_execute),
    .t1(t1), .t2(t2), .t3(t3), .t4(t4), .t5(t5), .fetch(fetch),
    .clear(clear), .inc1(inc1), .add(add), .dec1(dec1), .jmp(jmp), .buz(buz),
    .load(load), .store(store), .halted(halted), .paused(paused),
    .overrun(overrun), .icount(icount)
  );

  // {t5..t1, fetch, store..clear, halted, paused, overrun, icount}
  logic [20:0] dut_vec;
  assign dut_vec = {t5, t4, t3, t2, t1, fetch, store, load, buz, jmp, dec1, add, inc1,
                    clear, halted, paused, overrun, icount};
  localparam logic [20:0] RESET_VEC = {5'b0, 1'b0, 8'b0, 1'b1, 1'b0, 1'b0, 4'b0};

  typedef enum int {P_IDLE, P_FETCH, P_EXEC, P_WAIT, P_ERR} phase_t;
  phase_t ph = P_IDLE;
  int tn = 0;
  int op = 0;
  int icnt = 0;
  logic sm_g = 1'b0;

  logic [20:0] exp_q[$];
  int total = 0;
  int bad = 0;

  function automatic logic [20:0] expect_vec();
    logic [4:0] tv = 5'd0;
    logic [7:0] dv = 8'd0;
    if (ph == P_FETCH || ph == P_EXEC) tv = 5'(1 << (tn - 1));
    if (ph == P_EXEC) dv = 8'(1 << op);
    return {tv, ph == P_FETCH, dv, ph == P_IDLE, ph == P_WAIT, ph == P_ERR, 4'(icnt)};
  endfunction

  task automatic check(input string name, input logic [20:0] got, input logic [20:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s @%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  task automatic model_step(input logic r, input logic sm, input logic st,
                            input logic [2:0] opc, input logic sf, input logic se);
    case (ph)
      P_IDLE: if (r) begin ph = P_FETCH; tn = 1; end
      P_FETCH: begin
        if (sf && se) ph = P_ERR;
        else if (se) begin op = int'(opc); ph = P_EXEC; tn = 1; end
        else if (tn == MAX_T) ph = P_ERR;
        else tn++;
      end
      P_EXEC: begin
        if (sf && se) ph = P_ERR;
        else if (sf) begin
          icnt = (icnt + 1) % (1 << IW);
          $display("retire op=%0d icount=%0d t=%0d", op, icnt, tn);
          tn = 1;
          ph = !r ? P_IDLE : (sm ? P_WAIT : P_FETCH);
        end
        else if (tn == MAX_T) ph = P_ERR;
        else tn++;
      end
      P_WAIT: begin
        if (!r) ph = P_IDLE;
        else if (st) begin ph = P_FETCH; tn = 1; end
      end
      default: ;
    endcase
  endtask

  task automatic drive(input logic r, input logic sm, input logic st,
                       input logic [2:0] opc, input logic sf, input logic se);
    @(negedge clk);
    run = r; step_mode = sm; step = st; opcode = opc;
    start_fetch = sf; start_execute = se;
    model_step(r, sm, st, opc, sf, se);
    exp_q.push_back(expect_vec());
  endtask

  always @(posedge clk) begin
    logic [20:0] e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("cycle", dut_vec, e);
    end
  end

  // Asserts rst_n between clock edges and checks the outputs before any edge arrives.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    run = 0; step_mode = 0; step = 0; start_fetch = 0; start_execute = 0;
    #1 check("async_reset", dut_vec, RESET_VEC);
    exp_q.delete();
    ph = P_IDLE; tn = 0; op = 0; icnt = 0; sm_g = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic instr(input int fl, input int el, input int opc, input bit drop, input logic stp);
    for (int i = 1; i <= fl; i++)
      drive(1'b1, sm_g, stp, (i == fl) ? 3'(opc) : 3'($urandom), 1'b0, i == fl);
    for (int i = 1; i <= el; i++)
      drive(!(drop && i >= 2), sm_g, stp, 3'($urandom), i == el, 1'b0);
  endtask

  task automatic settle_check_icount(input string name, input int want);
    @(posedge clk);
    #2 check(name, 21'(icount), 21'(want));
  endtask

  initial begin
    // Reset, then the basic fetch(3)/execute(4) add instruction.
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    instr(3, 4, 2, 0, 0);
    instr(5, 5, 6, 0, 0);
    drive(1, 0, 0, 0, 0, 0);

    // All eight opcodes.
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    for (int o = 0; o < 8; o++) instr($urandom_range(1, 5), $urandom_range(1, 5), o, 0, 0);
    settle_check_icount("icount8", 8);

    // Single step: pause, hold, release, ignored steps, run priority over step.
    do_reset();
    sm_g = 1'b1;
    drive(1, 1, 0, 0, 0, 0);
    instr(2, 2, 5, 0, 0);
    repeat (5) drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    instr(2, 3, 4, 0, 1);
    drive(1, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    sm_g = 1'b0;

    // run dropped at execute t2.
    drive(1, 0, 0, 0, 0, 0);
    instr(2, 4, 1, 1, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0);

    // Overrun in fetch, then both handshakes together.
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    repeat (5) drive(1, 0, 0, 0, 0, 0);
    repeat (4) drive(1, 0, 1, 3'($urandom), 1'($urandom), 1'($urandom));
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 1);
    repeat (3) drive(1, 0, 0, 0, 0, 0);

    // Counter wrap with a 4-bit counter.
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    repeat (17) instr($urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(0, 7), 0, 0);
    settle_check_icount("icount_wrap", 1);

    // Randomized operation driven by a well-behaved control unit.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      logic r, sm, st, sf, se;
      r  = ($urandom % 10) != 0;
      sm = ($urandom % 4) == 0;
      st = ($urandom % 3) == 0;
      se = (ph == P_FETCH) && (tn == MAX_T || ($urandom % 3) == 0);
      sf = (ph == P_EXEC) && (tn == MAX_T || ($urandom % 3) == 0);
      if (ph == P_FETCH && !se && ($urandom % 8) == 0) sf = 1'b1;
      if (ph == P_EXEC && !sf && ($urandom % 8) == 0) se = 1'b1;
      drive(r, sm, st, 3'($urandom), sf, se);
    end

    // Asynchronous reset in the middle of an execute phase.
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 3, 0, 1);
    drive(1, 0, 0, 0, 0, 0);
    do_reset();
    drive(0, 0, 0, 0, 0, 0);

    @(posedge clk);
    #3 check("queue_drained", 21'(exp_q.size()), 21'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/patp_sequencer.md
Name: patp_sequencer

Overview:
Timing and phase sequencer for the PATP core. Generates one-hot T-states t1..t5, the fetch phase flag and the one-hot decoded-instruction lines that drive control_signal_generator, and consumes its start_fetch/start_execute handshakes. Adds run/halt control, single-step, an overrun watchdog and a retired-instruction counter.

Parameters:
MAX_T, 5, last legal T-state per phase (legal range 2..5); reaching it without a handshake is an overrun.
ICOUNT_W, 16, width of retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
run  in  1  level; 1 = execute program, 0 = stop at next instruction boundary.
step_mode  in  1  level; 1 = pause after every instruction.
step  in  1  single-cycle pulse; releases one instruction in step mode.
opcode  in  3  IR opcode field, valid when start_execute is high.
start_fetch  in  1  from control_signal_generator: end of execute phase.
start_execute  in  1  from control_signal_generator: end of fetch phase.
t1, t2, t3, t4, t5  out  1 each  one-hot timing state; all 0 outside FETCH/EXECUTE.
fetch  out  1  high throughout FETCH.
clear, inc1, add, dec1, jmp, buz, load, store  out  1 each  one-hot decoded instruction; high only in EXECUTE.
halted  out  1  high in IDLE.
paused  out  1  high in STEP_WAIT.
overrun  out  1  sticky error flag.
icount  out  ICOUNT_W  instructions retired.

Behaviour:
- All outputs registered. Reset: state IDLE, t1..t5=0, fetch=0, decode lines=0, halted=1, paused=0, overrun=0, icount=0, opcode latch=0.
- States: IDLE, FETCH, EXECUTE, STEP_WAIT, ERROR.
- IDLE: run=1 -> FETCH with t1 next cycle. Otherwise hold.
- FETCH: fetch=1. T advances t1->t2->... one per cycle. start_execute=1 -> next cycle EXECUTE at t1, opcode latched this cycle.
- EXECUTE: decode line per latched opcode: 000 clear, 001 inc1, 010 add, 011 dec1, 100 jmp, 101 buz, 110 load, 111 store. T advances as in FETCH. start_fetch=1 -> instruction retires: icount+1 (wraps to 0 at all-ones). Next state by priority: run=0 -> IDLE; step_mode=1 -> STEP_WAIT; else FETCH at t1.
- STEP_WAIT: T-states and decode lines 0, paused=1. step=1 -> FETCH at t1. run=0 -> IDLE (takes priority over step).
- Handshake latency: handshake sampled in cycle n; new phase t1 in cycle n+1. Fetch-to-execute and execute-to-fetch cost zero dead cycles.
- Handshakes ignored outside their own phase (start_fetch in FETCH, start_execute in EXECUTE, either in IDLE/STEP_WAIT).
- Overrun: in FETCH/EXECUTE at T-state MAX_T with no valid handshake that cycle -> ERROR next cycle. Handshake in the MAX_T cycle is legal.
- start_fetch and start_execute both high in same FETCH/EXECUTE cycle -> ERROR.
- ERROR: all T-states, fetch and decode lines 0; overrun=1. Exits only by rst_n.
- run falling mid-instruction does not abort; current instruction completes, then IDLE.
- step pulses outside STEP_WAIT ignored (not queued).
- rst_n asserted at any point: immediate return to reset values, including mid-phase.

Test Plan:
- Reset then run=1, fetch takes 3 cycles (start_execute at t3), opcode=010, execute takes 4 cycles (start_fetch at t4) -> fetch=1 with t1,t2,t3; then add=1 with t1..t4; then fetch/t1 again; icount=1.
- Run 8 instructions covering opcodes 000..111 -> exactly the matching decode line high each execute phase; icount=8.
- step_mode=1, one instruction -> paused=1, all T-states 0; hold 5 cycles; step pulse -> fetch/t1 next cycle; step while executing ignored.
- run dropped at execute t2 -> instruction finishes, icount increments, halted=1 next cycle after start_fetch.
- Fetch with no handshake through t5 (MAX_T=5) -> overrun=1 at next cycle, all outputs 0 and stays until rst_n low; repeat with both handshakes at t2 -> overrun.
- ICOUNT_W=4, retire 17 instructions -> icount=1; async rst_n pulse mid-execute -> outputs at reset values without a clock edge.
